// File: rtl/branch_exec_unit_pkg.sv
// Shared definitions for the branch execute unit: function codes and request/response records.
package branch_exec_unit_pkg;

  localparam int BRU_XLEN   = 32;
  localparam int BRU_TAG_W  = 5;
  localparam int BRU_FUNC_W = 6;

  localparam logic [5:0] FN_BEQ  = 6'h0e;
  localparam logic [5:0] FN_BNE  = 6'h0f;
  localparam logic [5:0] FN_BLT  = 6'h10;
  localparam logic [5:0] FN_BGE  = 6'h11;
  localparam logic [5:0] FN_BLTU = 6'h12;
  localparam logic [5:0] FN_BGEU = 6'h13;
  localparam logic [5:0] FN_JAL  = 6'h14;
  localparam logic [5:0] FN_JALR = 6'h15;
  localparam logic [5:0] FN_JUMP = 6'h16;

  // Default-width records used at the reservation-station / completion boundary.
  typedef struct packed {
    logic [BRU_FUNC_W-1:0] func;
    logic [BRU_XLEN-1:0]   pc;
    logic [BRU_XLEN-1:0]   imm;
    logic [BRU_XLEN-1:0]   rs1;
    logic [BRU_XLEN-1:0]   rs2;
    logic [BRU_TAG_W-1:0]  tag;
    logic                  pred_taken;
    logic [BRU_XLEN-1:0]   pred_target;
  } bru_req_t;

  typedef struct packed {
    logic [BRU_TAG_W-1:0] tag;
    logic                 taken;
    logic [BRU_XLEN-1:0]  next_pc;
    logic [BRU_XLEN-1:0]  link;
    logic                 mispredict;
  } bru_resp_t;

  function automatic logic is_branch_func(input logic [5:0] f);
    return (f >= FN_BEQ) && (f <= FN_JUMP);
  endfunction

endpackage

// File: rtl/branch_exec_unit_resolve.sv
// Combinational branch resolution: condition, target, link and misprediction for one request.
module bru_resolve
  import branch_exec_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int FUNC_W = 6
) (
  input  logic [FUNC_W-1:0] func_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic              pred_taken_i,
  input  logic [XLEN-1:0]   pred_target_i,
  output logic              taken_o,
  output logic [XLEN-1:0]   next_pc_o,
  output logic [XLEN-1:0]   link_o,
  output logic              mispredict_o
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;
  logic [XLEN-1:0]        target;
  logic [XLEN-1:0]        jalr_sum;
  logic                   known;

  assign rs1_s    = rs1_i;
  assign rs2_s    = rs2_i;
  assign jalr_sum = rs1_i + imm_i;
  assign link_o   = pc_i + XLEN'(4);

  always_comb begin
    known   = 1'b1;
    taken_o = 1'b0;
    target  = pc_i + imm_i;
    case (func_i)
      FUNC_W'(FN_BEQ):  taken_o = (rs1_i == rs2_i);
      FUNC_W'(FN_BNE):  taken_o = (rs1_i != rs2_i);
      FUNC_W'(FN_BLT):  taken_o = (rs1_s <  rs2_s);
      FUNC_W'(FN_BGE):  taken_o = (rs1_s >= rs2_s);
      FUNC_W'(FN_BLTU): taken_o = (rs1_i <  rs2_i);
      FUNC_W'(FN_BGEU): taken_o = (rs1_i >= rs2_i);
      FUNC_W'(FN_JAL):  taken_o = 1'b1;
      FUNC_W'(FN_JUMP): taken_o = 1'b1;
      FUNC_W'(FN_JALR): begin
        taken_o = 1'b1;
        target  = jalr_sum & ~XLEN'(1);
      end
      default:          known = 1'b0;
    endcase
  end

  // A not-taken prediction that matches never compares targets.
  assign next_pc_o    = taken_o ? target : link_o;
  assign mispredict_o = known & ((taken_o != pred_taken_i) |
                                 (taken_o & (target != pred_target_i)));

endmodule

// File: rtl/branch_exec_unit.sv
// Pipelined branch resolution unit with valid/ready backpressure and flush.
// Optional performance counters are enabled by defining BRU_PERF_CNT_EN.
module branch_exec_unit
  import branch_exec_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5,
  parameter int FUNC_W = 6,
  parameter int STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_pred_taken,
  input  logic [XLEN-1:0]   in_pred_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_taken,
  output logic [XLEN-1:0]   out_next_pc,
  output logic [XLEN-1:0]   out_link,
  output logic              out_mispredict
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispredicts
`endif
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             taken;
    logic [XLEN-1:0]  next_pc;
    logic [XLEN-1:0]  link;
    logic             mispredict;
  } resp_t;

  resp_t              resp_d;
  resp_t              resp_q     [STAGES];
  resp_t              chain_resp [STAGES+1];
  resp_t              resp_out;
  logic [STAGES-1:0]  vld_q;
  logic [STAGES:0]    chain_vld;
  logic [STAGES-1:0]  load_w;

  // Stage 0 input: all computation happens here, later stages only copy.
  bru_resolve #(
    .XLEN   (XLEN),
    .FUNC_W (FUNC_W)
  ) u_resolve (
    .func_i        (in_func),
    .pc_i          (in_pc),
    .imm_i         (in_imm),
    .rs1_i         (in_rs1),
    .rs2_i         (in_rs2),
    .pred_taken_i  (in_pred_taken),
    .pred_target_i (in_pred_target),
    .taken_o       (resp_d.taken),
    .next_pc_o     (resp_d.next_pc),
    .link_o        (resp_d.link),
    .mispredict_o  (resp_d.mispredict)
  );
  assign resp_d.tag = in_tag;

  // A stage loads when empty or when everything downstream of it moves.
  always_comb begin
    logic r;
    r = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      load_w[i] = ~vld_q[i] | r;
      r         = load_w[i];
    end
  end

  assign in_ready  = load_w[0];
  assign chain_vld = {vld_q, in_valid};

  always_comb begin
    chain_resp[0] = resp_d;
    for (int i = 0; i < STAGES; i++) chain_resp[i+1] = resp_q[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) resp_q[i] <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load_w[i]) begin
          vld_q[i] <= chain_vld[i];
          if (chain_vld[i]) resp_q[i] <= chain_resp[i];
        end
      end
    end
  end

  // Output stage boundary
  assign resp_out       = resp_q[STAGES-1];
  assign out_valid      = vld_q[STAGES-1];
  assign out_tag        = resp_out.tag;
  assign out_taken      = resp_out.taken;
  assign out_next_pc    = resp_out.next_pc;
  assign out_link       = resp_out.link;
  assign out_mispredict = resp_out.mispredict;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q;
  logic [31:0] perf_mp_q;

  // Counts every delivered result, including one delivered during a flush.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else if (out_valid && out_ready) begin
      perf_br_q <= perf_br_q + 32'd1;
      if (out_mispredict) perf_mp_q <= perf_mp_q + 32'd1;
    end
  end

  assign perf_branches    = perf_br_q;
  assign perf_mispredicts = perf_mp_q;
`endif

endmodule
